// File: rtl/alu_exec_ctrl_if.sv
// Bundle between the execute controller and its environment: instruction
// handshake, ALU operand/result bus, register load/debug port, status.
interface alu_exec_ctrl_if #(
   parameter int RAW = 2
);
   logic           instr_valid;
   logic           instr_ready;
   logic [3:0]     instr_op;
   logic [RAW-1:0] instr_rd;
   logic [RAW-1:0] instr_rs;
   logic [RAW-1:0] instr_rt;
   logic           instr_use_imm;
   logic [7:0]     instr_imm;
   logic           instr_wb;

   logic [7:0]     alu_a;
   logic [7:0]     alu_b;
   logic [3:0]     alu_op;
   logic [7:0]     alu_c;
   logic [7:0]     alu_flags;

   logic           ld_en;
   logic [RAW-1:0] ld_addr;
   logic [7:0]     ld_data;
   logic [RAW-1:0] dbg_addr;
   logic [7:0]     dbg_data;

   logic [7:0]     flags_q;
   logic [7:0]     result_q;
   logic           done;

   modport master (
      output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
             instr_use_imm, instr_imm, instr_wb,
             alu_c, alu_flags, ld_en, ld_addr, ld_data, dbg_addr,
      input  instr_ready, alu_a, alu_b, alu_op, dbg_data,
             flags_q, result_q, done
   );

   modport slave (
      input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
             instr_use_imm, instr_imm, instr_wb,
             alu_c, alu_flags, ld_en, ld_addr, ld_data, dbg_addr,
      output instr_ready, alu_a, alu_b, alu_op, dbg_data,
             flags_q, result_q, done
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Serialised IDLE -> EXEC -> WB controller that feeds a sibling 8-bit ALU
// from a small register file and writes the result (or only flags) back.
//
//  state  | meaning
//  S_IDLE | ready for an instruction; operands latched on handshake
//  S_EXEC | ALU operands stable; result and flags captured at end of cycle
//  S_WB   | done pulse; flags committed, result written to rd if wb
module alu_exec_ctrl #(
   parameter int NREGS = 4,
   parameter int RAW   = 2
) (
   input  logic clk,
   input  logic rst,
   alu_exec_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nx;
   logic           w_ready;
   logic           w_done;
   logic           w_accept;

   logic [7:0]     r_regs [NREGS];
   logic [7:0]     r_a;
   logic [7:0]     r_b;
   logic [3:0]     r_op;
   logic [RAW-1:0] r_rd;
   logic           r_wb;
   logic [7:0]     r_result;
   logic [7:0]     r_flg_n;
   logic [7:0]     r_flags;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_ready    = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.instr_valid) w_state_nx = S_EXEC;
         end
         S_EXEC:  w_state_nx = S_WB;
         S_WB: begin
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign w_accept = w_ready & bus.instr_valid;

   // Operands come from the register array before any same-cycle load lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a  <= '0;
         r_b  <= '0;
         r_op <= '0;
         r_rd <= '0;
         r_wb <= 1'b0;
      end else if (w_accept) begin
         r_a  <= r_regs[bus.instr_rs];
         r_b  <= bus.instr_use_imm ? bus.instr_imm : r_regs[bus.instr_rt];
         r_op <= bus.instr_op;
         r_rd <= bus.instr_rd;
         r_wb <= bus.instr_wb;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_flg_n  <= '0;
         r_flags  <= '0;
      end else begin
         if (r_state == S_EXEC) begin
            r_result <= bus.alu_c;
            r_flg_n  <= bus.alu_flags;
         end
         if (w_done) r_flags <= r_flg_n;
      end
   end

   // Writeback is the later assignment so it overrides a load to the same address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         if (bus.ld_en)     r_regs[bus.ld_addr] <= bus.ld_data;
         if (w_done && r_wb) r_regs[r_rd]       <= r_result;
      end
   end

   assign bus.instr_ready = w_ready & ~rst;
   assign bus.alu_a       = r_a;
   assign bus.alu_b       = r_b;
   assign bus.alu_op      = r_op;
   assign bus.dbg_data    = r_regs[bus.dbg_addr];
   assign bus.flags_q     = r_flags;
   assign bus.result_q    = r_result;
   assign bus.done        = w_done;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomised bench for alu_exec_ctrl: a behavioural ALU stands in for the
// sibling block, and a register-array reference model predicts every result.
module tb_alu_exec_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   alu_exec_ctrl_if #(.RAW(2)) bus ();

   alu_exec_ctrl #(.NREGS(4), .RAW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   int acc_q[$];

   logic [7:0] m_regs [4];
   logic [7:0] m_flags;

   // Behavioural ALU: returns {flags, result}; flags = {2'b0, ovf, par, sign, zero, aux, carry}
   function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      logic [8:0] w;
      logic [4:0] n;
      logic [7:0] c;
      logic [7:0] bb;
      logic cy, ac, ov;
      cy = 1'b0; ac = 1'b0; ov = 1'b0; w = '0; n = '0;
      bb = (op == 4'd5 || op == 4'd6) ? 8'd1 : b;
      case (op)
         4'd0, 4'd5: begin
            w  = {1'b0, a} + {1'b0, bb};
            n  = {1'b0, a[3:0]} + {1'b0, bb[3:0]};
            c  = w[7:0];
            cy = w[8]; ac = n[4];
            ov = (a[7] == bb[7]) && (c[7] != a[7]);
         end
         4'd1, 4'd6: begin
            w  = {1'b0, a} - {1'b0, bb};
            n  = {1'b0, a[3:0]} - {1'b0, bb[3:0]};
            c  = w[7:0];
            cy = w[8]; ac = n[4];
            ov = (a[7] != bb[7]) && (c[7] != a[7]);
         end
         4'd2:    c = a & b;
         4'd3:    c = a | b;
         4'd4:    c = a ^ b;
         4'd7:    c = a << b[2:0];
         4'd8:    c = a >> b[2:0];
         4'd9:    c = b;
         default: c = ~a;
      endcase
      return {2'b00, ov, ~^c, c[7], (c == 8'h00), ac, cy, c};
   endfunction

   assign {bus.alu_flags, bus.alu_c} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

   always @(posedge clk) cyc <= cyc + 1;

   // Observe the handshake and done just before the rising edge.
   always @(negedge clk) begin
      #8;
      if (!rst && bus.instr_valid && bus.instr_ready) acc_q.push_back(cyc);
      if (bus.done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 4; i++) begin
         bus.dbg_addr = 2'(i);
         #1;
         chk($sformatf("%s_r%0d", tag, i), bus.dbg_data, m_regs[i]);
      end
   endtask

   task automatic ld(input logic [1:0] a, input logic [7:0] d);
      bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
      @(negedge clk);
      bus.ld_en = 1'b0;
      m_regs[a] = d;
   endtask

   task automatic set_fields(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [1:0] rt, input logic ui, input logic [7:0] imm,
                             input logic wb);
      bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs = rs; bus.instr_rt = rt;
      bus.instr_use_imm = ui; bus.instr_imm = imm; bus.instr_wb = wb;
   endtask

   task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                             input logic [1:0] rt, input logic ui, input logic [7:0] imm,
                             input logic wb);
      logic [15:0] r;
      r = alu_fn(op, m_regs[rs], ui ? imm : m_regs[rt]);
      if (wb) m_regs[rd] = r[7:0];
      m_flags = r[15:8];
   endtask

   // One full instruction from the IDLE negedge; ldw: 0 none, 1 load with handshake, 2 load in WB.
   task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic [1:0] rt, input logic ui, input logic [7:0] imm,
                            input logic wb, input int ldw, input logic [1:0] la,
                            input logic [7:0] ldd);
      logic [7:0]  a, b;
      logic [15:0] r;
      a = m_regs[rs];
      b = ui ? imm : m_regs[rt];
      r = alu_fn(op, a, b);
      set_fields(op, rd, rs, rt, ui, imm, wb);
      bus.instr_valid = 1'b1;
      if (ldw == 1) begin bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldd; end
      chk("hs_ready", bus.instr_ready, 1'b1);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.ld_en = 1'b0;
      if (ldw == 1) m_regs[la] = ldd;
      chk("exec_ready", bus.instr_ready, 1'b0);
      chk("exec_done", bus.done, 1'b0);
      chk("alu_a", bus.alu_a, a);
      chk("alu_b", bus.alu_b, b);
      chk("alu_op", bus.alu_op, op);
      @(negedge clk);
      chk("wb_done", bus.done, 1'b1);
      chk("result_q", bus.result_q, r[7:0]);
      if (ldw == 2) begin bus.ld_en = 1'b1; bus.ld_addr = la; bus.ld_data = ldd; end
      @(negedge clk);
      bus.ld_en = 1'b0;
      if (ldw == 2) m_regs[la] = ldd;
      if (wb) m_regs[rd] = r[7:0];
      m_flags = r[15:8];
      chk("flags_q", bus.flags_q, m_flags);
      chk("idle_ready", bus.instr_ready, 1'b1);
      chk("idle_done", bus.done, 1'b0);
      check_regs("wb");
   endtask

   logic [3:0] h_op [3];
   logic [1:0] h_rd [3];
   logic [1:0] h_rs [3];
   logic [1:0] h_rt [3];
   logic       h_ui [3];
   logic [7:0] h_imm[3];

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, base, n, last;
      bus.instr_valid = 1'b0;
      set_fields(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0);
      bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.dbg_addr = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_flags = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst_ready", bus.instr_ready, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_flags", bus.flags_q, 8'h00);
      chk("rst_result", bus.result_q, 8'h00);
      chk("rst_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, 20'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", bus.instr_ready, 1'b1);
      check_regs("rst");

      // Reset while in EXEC aborts the instruction
      ld(2'd0, 8'h7F);
      set_fields(4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1);
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk("mid_exec_ready", bus.instr_ready, 1'b0);
      d0 = done_cnt;
      #2 rst = 1'b1;
      bus.dbg_addr = 2'd0;
      #1;
      chk("mid_rst_r0", bus.dbg_data, 8'h00);
      chk("mid_rst_ready", bus.instr_ready, 1'b0);
      chk("mid_rst_alu_a", bus.alu_a, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_flags = 8'h00;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_done", done_cnt, d0);
      chk("mid_rst_flags", bus.flags_q, 8'h00);
      chk("mid_rst_idle", bus.instr_ready, 1'b1);
      check_regs("mid_rst");

      // Overflowing ADD with writeback
      ld(2'd0, 8'h7F); ld(2'd1, 8'h01);
      run_instr(4'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 0, 2'd0, 8'h00);
      bus.dbg_addr = 2'd2; #1;
      chk("add_r2", bus.dbg_data, 8'h80);
      chk("add_flags", bus.flags_q, 8'h2A);

      // Compare mode: flags only
      ld(2'd0, 8'h05); ld(2'd1, 8'h05);
      run_instr(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 1'b0, 0, 2'd0, 8'h00);
      bus.dbg_addr = 2'd0; #1;
      chk("cmp_r0", bus.dbg_data, 8'h05);
      chk("cmp_result", bus.result_q, 8'h00);
      chk("cmp_flags", bus.flags_q, 8'h14);

      // INC wraps, dependent ADD immediate issued at the earliest slot
      ld(2'd1, 8'hFF);
      run_instr(4'd5, 2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 1'b1, 0, 2'd0, 8'h00);
      chk("inc_carry", bus.flags_q[0], 1'b1);
      a0 = acc_q[$];
      run_instr(4'd0, 2'd3, 2'd1, 2'd0, 1'b1, 8'h10, 1'b1, 0, 2'd0, 8'h00);
      bus.dbg_addr = 2'd3; #1;
      chk("chain_r3", bus.dbg_data, 8'h10);
      chk("chain_gap", acc_q[$] - a0, 3);

      // instr_valid held high across three distinct instructions
      ld(2'd0, 8'h11); ld(2'd1, 8'h22);
      h_op[0] = 4'd0; h_rd[0] = 2'd2; h_rs[0] = 2'd0; h_rt[0] = 2'd1; h_ui[0] = 1'b0; h_imm[0] = 8'h00;
      h_op[1] = 4'd1; h_rd[1] = 2'd3; h_rs[1] = 2'd2; h_rt[1] = 2'd0; h_ui[1] = 1'b0; h_imm[1] = 8'h00;
      h_op[2] = 4'd4; h_rd[2] = 2'd0; h_rs[2] = 2'd3; h_rt[2] = 2'd0; h_ui[2] = 1'b1; h_imm[2] = 8'h5A;
      d0 = done_cnt;
      base = acc_q.size();
      n = 0;
      last = -100;
      set_fields(h_op[0], h_rd[0], h_rs[0], h_rt[0], h_ui[0], h_imm[0], 1'b1);
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 20 && n < 3; k++) begin
         @(negedge clk);
         if (acc_q.size() - base > n) begin
            n++;
            last = acc_q[$];
            if (n < 3) set_fields(h_op[n], h_rd[n], h_rs[n], h_rt[n], h_ui[n], h_imm[n], 1'b1);
            else       bus.instr_valid = 1'b0;
         end
         if (n < 3) chk("hold_ready", bus.instr_ready, (cyc - last) >= 3);
      end
      chk("hold_accepts", n, 3);
      if (n == 3) begin
         chk("hold_gap1", acc_q[base+1] - acc_q[base], 3);
         chk("hold_gap2", acc_q[base+2] - acc_q[base+1], 3);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) model_exec(h_op[i], h_rd[i], h_rs[i], h_rt[i], h_ui[i], h_imm[i], 1'b1);
      chk("hold_done_cnt", done_cnt - d0, 3);
      chk("hold_flags", bus.flags_q, m_flags);
      check_regs("hold");

      // Load colliding with writeback: WB wins on same address, other address loads
      ld(2'd0, 8'h0F); ld(2'd1, 8'hFF);
      run_instr(4'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 2, 2'd2, 8'hAA);
      bus.dbg_addr = 2'd2; #1;
      chk("coll_r2", bus.dbg_data, 8'h0F);
      run_instr(4'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 1'b1, 2, 2'd3, 8'hAA);
      bus.dbg_addr = 2'd3; #1;
      chk("coll_r3", bus.dbg_data, 8'hAA);

      // Load coinciding with the handshake: operand sees pre-load value
      run_instr(4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 1'b1, 1, 2'd0, 8'h33);
      bus.dbg_addr = 2'd1; #1;
      chk("hs_load_r1", bus.dbg_data, 8'h1E);

      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(3) == 0) ld(2'($urandom_range(3)), 8'($urandom));
         run_instr(4'($urandom_range(15)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                   2'($urandom_range(3)), 1'($urandom_range(1)), 8'($urandom),
                   1'($urandom_range(1)), int'($urandom_range(2)), 2'($urandom_range(3)),
                   8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute controller that sequences the shared 8-bit combinational ALU (16 ops, 4-bit opcode, 8-bit flags output) for a small register file. It accepts one instruction per handshake, reads operands from an internal NREGS x 8 register file, drives the ALU, and latches result and flags. It then writes the result back, or only updates flags in compare mode, and pulses done. It sits between the instruction decoder (upstream) and the ALU instance (sibling, wired through alu_* ports).

Parameters:
NREGS, 4, number of 8-bit general registers (power of 2, >=2)
RAW, 2, register address width, equals log2(NREGS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
instr_op  in  4  ALU opcode, passed to ALU unchanged
instr_rd  in  RAW  destination register
instr_rs  in  RAW  source A register
instr_rt  in  RAW  source B register
instr_use_imm  in  1  1: B operand = instr_imm; 0: B operand = reg[instr_rt]
instr_imm  in  8  immediate B operand (also the shift amount for shift ops)
instr_wb  in  1  1: write result to rd; 0: compare mode, flags only
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_op  out  4  ALU opcode
alu_c  in  8  ALU result
alu_flags  in  8  ALU flags {2'b0, ovf, par, sign, zero, aux, carry}
ld_en  in  1  external register load strobe
ld_addr  in  RAW  load address
ld_data  in  8  load data
dbg_addr  in  RAW  debug read address
dbg_data  out  8  combinational reg[dbg_addr]
flags_q  out  8  architectural flags register
result_q  out  8  last ALU result
done  out  1  one-cycle pulse in WB state

Behaviour:
- Reset is asynchronous and active-high, on rst:
  - state = IDLE
  - all registers = 0
  - alu_a/alu_b/alu_op = 0
  - flags_q = 0, result_q = 0, done = 0
  - instr_ready deasserts while rst is high.
- Reset mid-operation aborts the instruction: no writeback, no flags update, no done pulse.
- States: IDLE -> EXEC -> WB -> IDLE. The controller is fully serialised; throughput is one instruction per 3 cycles.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch:
    - a_q = reg[rs]
    - b_q = use_imm ? imm : reg[rt]
    - op_q, rd_q, wb_q
  - Then go to EXEC. instr_valid while not in IDLE is ignored (ready = 0). The requester must hold its fields until the handshake completes.
- alu_a = a_q, alu_b = b_q, alu_op = op_q. These are driven from registers and are stable throughout EXEC and WB.
- EXEC: at the clock edge, capture alu_c into result_q and alu_flags into flg_n, then go to WB.
- WB:
  - done = 1.
  - flags_q <= flg_n for every op, including compare mode.
  - If wb_q = 1, reg[rd_q] <= result_q. If wb_q = 0, registers are unchanged.
  - Then go to IDLE.
- Latency: handshake in cycle T; result_q valid at T+2; reg[rd] and flags_q visible at T+3; instr_ready high again at T+3.
- Back-to-back dependency: a second instruction accepted at T+3 reads the value written in WB. No bypass is needed.
- ld_en is accepted in any state.
  - If ld_en and a WB write hit the same address in the same cycle, WB wins.
  - If a load and a handshake coincide, the operand read gets the pre-load value.
- dbg_data is combinational and shows the written value from the cycle after the write.
- All arithmetic is 8-bit. The controller never interprets opcodes; ALU semantics, including shift amounts from b, are the ALU's.

Test Plan:
- Reset mid-EXEC: ld r0=0x7F, ADD issued, assert rst in EXEC -> state IDLE, r0=0, flags_q=0, no done pulse.
- Overflowing ADD with writeback:
  - Setup: ld r0=0x7F, r1=0x01; ADD rd=r2 rs=r0 rt=r1 wb=1.
  - Required: done at T+2, r2=0x80, flags_q=0x2A.
- Compare mode: ld r0=0x05, r1=0x05; SUB rd=r0 wb=0 -> r0 stays 0x05, result_q=0x00, flags_q=0x14.
- Immediate and dependency chain:
  - Issue INC rd=r1 rs=r1 (r1=0xFF), then immediately ADD rd=r3 rs=r1 imm=0x10 use_imm=1.
  - Required: r1=0x00 with carry=1, then r3=0x10. Second handshake no earlier than 3 cycles after the first.
- Handshake hold: keep instr_valid high continuously with 3 distinct instructions -> exactly 3 accepts, spaced 3 cycles apart, instr_ready low in EXEC/WB.
- Load/WB collision: in the WB cycle of AND rd=r2 (result 0x0F), drive ld_en to r2 with 0xAA -> r2=0x0F. A load to r3 in the same cycle -> r3=0xAA.
